// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition codes and flag bit indices for cond_unit
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_sat_counter.sv
// rtl/cond_unit_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // next count: clear wins, otherwise increment and stick at all-ones
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag register, condition check and write gating; COND_PERF_CNT_EN adds debug counters
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             InstrValid,
    input  logic             Stall,
    input  logic             CntClr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);

    logic [3:0] flags_d;
    logic [3:0] flags_q;
    logic       cond_ex;
    logic       flag_upd;

    logic n_f, z_f, c_f, v_f;

    assign n_f = flags_q[FLAG_N];
    assign z_f = flags_q[FLAG_Z];
    assign c_f = flags_q[FLAG_C];
    assign v_f = flags_q[FLAG_V];

    // condition decode against the registered flags only (no bypass of ALUFlags)
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            default: cond_ex = 1'b1;
        endcase
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS  & cond_ex & InstrValid;
    assign RegWrite = RegW & cond_ex & ~NoWrite & InstrValid;
    assign MemWrite = MemW & cond_ex & InstrValid;

    // only an executed, non-stalled instruction may touch the flags
    assign flag_upd = cond_ex & InstrValid & ~Stall;

    // next flags: N,Z and C,V pairs load independently
    always_comb begin
        flags_d = flags_q;
        if (flag_upd) begin
            if (FlagW[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    // architectural status flag register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags = flags_q;

`ifdef COND_PERF_CNT_EN
    logic cnt_evt;
    logic exec_inc;
    logic skip_inc;

    // unconditional (AL/NV) instructions are not interesting for the debug counts
    assign cnt_evt  = InstrValid & ~Stall & (Cond != COND_AL) & (Cond != COND_NV);
    assign exec_inc = cnt_evt & cond_ex;
    assign skip_inc = cnt_evt & ~cond_ex;

    sat_counter #(.W(CNT_W)) u_exec_cnt (
        .clk   (CLK),
        .rst_n (RESETn),
        .inc   (exec_inc),
        .clr   (CntClr),
        .count (ExecCnt)
    );

    sat_counter #(.W(CNT_W)) u_skip_cnt (
        .clk   (CLK),
        .rst_n (RESETn),
        .inc   (skip_inc),
        .clr   (CntClr),
        .count (SkipCnt)
    );
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = CntClr;
    assign ExecCnt        = '0;
    assign SkipCnt        = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs, reg_w, mem_w, no_write, instr_valid, stall, cnt_clr;
    logic             pc_src, reg_write, mem_write, cond_ex;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_cnt, skip_cnt;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .CLK        (clk),
        .RESETn     (rst_n),
        .Cond       (cond),
        .ALUFlags   (alu_flags),
        .FlagW      (flag_w),
        .PCS        (pcs),
        .RegW       (reg_w),
        .MemW       (mem_w),
        .NoWrite    (no_write),
        .InstrValid (instr_valid),
        .Stall      (stall),
        .CntClr     (cnt_clr),
        .PCSrc      (pc_src),
        .RegWrite   (reg_write),
        .MemWrite   (mem_write),
        .CondEx     (cond_ex),
        .Flags      (flags),
        .ExecCnt    (exec_cnt),
        .SkipCnt    (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [3:0]       m_flags;
    logic [CNT_W-1:0] m_exec, m_skip;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: observe = {31'd0, cond_ex};
            1: observe = {31'd0, pc_src};
            2: observe = {31'd0, reg_write};
            3: observe = {31'd0, mem_write};
            4: observe = {28'd0, flags};
            5: observe = {{(32-CNT_W){1'b0}}, exec_cnt};
            default: observe = {{(32-CNT_W){1'b0}}, skip_cnt};
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if      (c == 4'd0)  ref_cond = z;
        else if (c == 4'd1)  ref_cond = !z;
        else if (c == 4'd2)  ref_cond = cy;
        else if (c == 4'd3)  ref_cond = !cy;
        else if (c == 4'd4)  ref_cond = n;
        else if (c == 4'd5)  ref_cond = !n;
        else if (c == 4'd6)  ref_cond = v;
        else if (c == 4'd7)  ref_cond = !v;
        else if (c == 4'd8)  ref_cond = cy && !z;
        else if (c == 4'd9)  ref_cond = !cy || z;
        else if (c == 4'd10) ref_cond = (n == v);
        else if (c == 4'd11) ref_cond = (n != v);
        else if (c == 4'd12) ref_cond = !z && (n == v);
        else if (c == 4'd13) ref_cond = z || (n != v);
        else                 ref_cond = 1'b1;
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_", e.tag}, observe(e.sel), e.val);
        end
    endtask

    // one instruction; called at a negedge, returns at the next negedge
    task automatic run_cycle(input string tag, input logic [3:0] c, input logic [3:0] alu,
                             input logic [1:0] fw, input logic p, input logic rw, input logic mw,
                             input logic nw, input logic vld, input logic stl, input logic clr);
        logic ex;
        cond = c; alu_flags = alu; flag_w = fw; pcs = p; reg_w = rw; mem_w = mw;
        no_write = nw; instr_valid = vld; stall = stl; cnt_clr = clr;
        ex = ref_cond(c, m_flags);
        push_exp("condex", 0, {31'd0, ex});
        push_exp("pcsrc",  1, {31'd0, p & ex & vld});
        push_exp("regwr",  2, {31'd0, rw & ex & !nw & vld});
        push_exp("memwr",  3, {31'd0, mw & ex & vld});
        #1;
        drain(tag);
        if (ex && vld && !stl) begin
            if (fw[1]) m_flags[3:2] = alu[3:2];
            if (fw[0]) m_flags[1:0] = alu[1:0];
        end
`ifdef COND_PERF_CNT_EN
        if (clr) begin
            m_exec = '0;
            m_skip = '0;
        end else if (vld && !stl && c != 4'hE && c != 4'hF) begin
            if (ex && m_exec != '1) m_exec = m_exec + 1'b1;
            if (!ex && m_skip != '1) m_skip = m_skip + 1'b1;
        end
`endif
        push_exp("flags", 4, {28'd0, m_flags});
        push_exp("exec",  5, {{(32-CNT_W){1'b0}}, m_exec});
        push_exp("skip",  6, {{(32-CNT_W){1'b0}}, m_skip});
        @(posedge clk);
        #1;
        drain(tag);
        @(negedge clk);
    endtask

    task automatic set_flags(input logic [3:0] f);
        run_cycle("setf", 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cond = 4'h0; alu_flags = 4'h0; flag_w = 2'b00;
        pcs = 0; reg_w = 0; mem_w = 0; no_write = 0; instr_valid = 0; stall = 0; cnt_clr = 0;
        m_flags = 4'h0; m_exec = '0; m_skip = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_flags", {28'd0, flags}, 32'h0);
        check_eq("rst_exec", {{(32-CNT_W){1'b0}}, exec_cnt}, 32'h0);
        check_eq("rst_skip", {{(32-CNT_W){1'b0}}, skip_cnt}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // EQ after reset fails: Z=0
        run_cycle("eq_after_rst", 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("eq_after_rst_pcsrc", {31'd0, pc_src}, 32'h0);

        // CMP-style: sets Z, RegWrite suppressed
        run_cycle("cmp", 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("cmp_flags", {28'd0, flags}, 32'h4);
        run_cycle("ne_after_cmp", 4'h1, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle("eq_after_cmp", 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // partial write: only N,Z load
        set_flags(4'hF);
        run_cycle("partial", 4'hE, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("partial_flags", {28'd0, flags}, 32'h3);

        // sweep every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                run_cycle($sformatf("sweep_c%0d_f%0h", c, f), 4'(c), 4'(15 - f), 2'b00,
                          1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end

        // spot checks: GT with N=1,V=1,Z=0 and LE with N=1,V=0
        set_flags(4'b1001);
        cond = 4'hC; instr_valid = 1'b1; flag_w = 2'b00;
        #1;
        check_eq("gt_nv_set", {31'd0, cond_ex}, 32'h1);
        @(negedge clk);
        set_flags(4'b1000);
        cond = 4'hD; flag_w = 2'b00;
        #1;
        check_eq("le_n_not_v", {31'd0, cond_ex}, 32'h1);
        @(negedge clk);

        // failed condition and stall never write the flags
        set_flags(4'h0);
        run_cycle("failed_s", 4'h0, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("failed_s_flags", {28'd0, flags}, 32'h0);
        run_cycle("stall_s", 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("stall_s_flags", {28'd0, flags}, 32'h0);

        // counters: clear, 20 skipped MI, then clear with an executed EQ
        run_cycle("clr0", 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_cycle($sformatf("mi_skip%0d", i), 4'h4, 4'h0, 2'b00,
                      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
`ifdef COND_PERF_CNT_EN
        check_eq("skip_sat", {{(32-CNT_W){1'b0}}, skip_cnt}, 32'hF);
`else
        check_eq("skip_tied", {{(32-CNT_W){1'b0}}, skip_cnt}, 32'h0);
`endif
        set_flags(4'b0100);
        run_cycle("eq_exec", 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle("clr_eq", 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("clr_eq_exec", {{(32-CNT_W){1'b0}}, exec_cnt}, 32'h0);

        // asynchronous reset between edges
        set_flags(4'hA);
        run_cycle("pre_rst_ne", 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_flags", {28'd0, flags}, 32'h0);
        check_eq("async_rst_exec", {{(32-CNT_W){1'b0}}, exec_cnt}, 32'h0);
        m_flags = 4'h0; m_exec = '0; m_skip = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("post_rst_eq", 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
